// File: rtl/hopfield_learner.sv
`default_nettype none
// ============================================================================
//  Module   : hopfield_learner
//  Purpose  : Sequential Hebbian trainer for an N-neuron Hopfield network.
//             Accepts N-bit patterns over valid/ready and walks all N*N
//             link weights, one per clock, applying a saturating +1/-1.
//             A registered read port lets the recall engine fetch
//             weight[k*N+m].
//  Options  : define ZERO_DIAG_EN to force diagonal weights (k==m) to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module hopfield_learner #(
    parameter int N       = 25,
    parameter int WW      = 4,
    parameter int MAX_PAT = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          pat_valid,
    input  logic [N-1:0]  pat_data,
    output logic          pat_ready,
    output logic          busy,
    output logic          learn_done,
    output logic [3:0]    pat_count,
    input  logic [9:0]    rd_addr,
    output logic [WW-1:0] rd_data
);

    localparam int                c_DEPTH = N * N;
    localparam int                c_KW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [9:0]        c_LAST  = 10'(c_DEPTH - 1);
    localparam logic [c_KW-1:0]   c_MLAST = c_KW'(N - 1);
    localparam logic [3:0]        c_PMAX  = 4'(MAX_PAT);
    localparam logic signed [WW:0] c_WMAX = (WW+1)'((1 << (WW - 1)) - 1);
    localparam logic signed [WW:0] c_WMIN = (WW+1)'(-(1 << (WW - 1)));

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_LEARN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [9:0]        addr_q, addr_d;
    logic [c_KW-1:0]   k_q, k_d;
    logic [c_KW-1:0]   m_q, m_d;
    logic [N-1:0]      pat_q, pat_d;
    logic [3:0]        pat_count_q, pat_count_d;
    logic              learn_done_q, learn_done_d;
    logic [WW-1:0]     rd_data_q;

    // Weight store; contents are undefined until the CLEAR sweep has run.
    logic [WW-1:0]     mem_q [c_DEPTH];

    logic              w_we;
    logic [WW-1:0]     w_wdata;
    logic              w_ready;
    logic [WW-1:0]     w_old;
    logic signed [WW:0] w_delta;
    logic signed [WW:0] w_sum;
    logic [WW-1:0]     w_sat;

    // Hebbian increment for the current weight, clamped to the signed range.
    always_comb begin
        w_old   = mem_q[addr_q];
        w_delta = (pat_q[k_q] == pat_q[m_q]) ? (WW+1)'(1) : (WW+1)'(-1);
        w_sum   = $signed({w_old[WW-1], w_old}) + w_delta;
        if (w_sum > c_WMAX) begin
            w_sat = c_WMAX[WW-1:0];
        end else if (w_sum < c_WMIN) begin
            w_sat = c_WMIN[WW-1:0];
        end else begin
            w_sat = w_sum[WW-1:0];
        end
`ifdef ZERO_DIAG_EN
        if (k_q == m_q) begin
            w_sat = '0;
        end
`endif
    end

    // Next-state logic: clear sweep, idle handshake, learn sweep.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        k_d          = k_q;
        m_d          = m_q;
        pat_d        = pat_q;
        pat_count_d  = pat_count_q;
        learn_done_d = 1'b0;
        w_we         = 1'b0;
        w_wdata      = '0;
        w_ready      = 1'b0;
        case (state_q)
            S_CLEAR: begin
                w_we    = 1'b1;
                w_wdata = '0;
                if (addr_q == c_LAST) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 10'd1;
                end
            end
            S_IDLE: begin
                // clear has priority over a pattern offered in the same cycle
                w_ready = !clear && (pat_count_q < c_PMAX);
                if (clear) begin
                    state_d     = S_CLEAR;
                    addr_d      = '0;
                    pat_count_d = '0;
                end else if (pat_valid && w_ready) begin
                    state_d = S_LEARN;
                    pat_d   = pat_data;
                    addr_d  = '0;
                    k_d     = '0;
                    m_d     = '0;
                end
            end
            S_LEARN: begin
                w_we    = 1'b1;
                w_wdata = w_sat;
                if (addr_q == c_LAST) begin
                    state_d      = S_IDLE;
                    addr_d       = '0;
                    k_d          = '0;
                    m_d          = '0;
                    learn_done_d = 1'b1;
                    if (pat_count_q < c_PMAX) begin
                        pat_count_d = pat_count_q + 4'd1;
                    end
                end else begin
                    addr_d = addr_q + 10'd1;
                    if (m_q == c_MLAST) begin
                        m_d = '0;
                        k_d = k_q + c_KW'(1);
                    end else begin
                        m_d = m_q + c_KW'(1);
                    end
                end
            end
            default: begin
                state_d = S_CLEAR;
                addr_d  = '0;
            end
        endcase
    end

    // Control registers; reset always restarts the clear sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            addr_q       <= '0;
            k_q          <= '0;
            m_q          <= '0;
            pat_q        <= '0;
            pat_count_q  <= '0;
            learn_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            k_q          <= k_d;
            m_q          <= m_d;
            pat_q        <= pat_d;
            pat_count_q  <= pat_count_d;
            learn_done_q <= learn_done_d;
        end
    end

    // Weight RAM write port (no reset, cleared by the CLEAR sweep).
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_q[addr_q] <= w_wdata;
        end
    end

    // Registered read port; out-of-range addresses read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_addr <= c_LAST) begin
            rd_data_q <= mem_q[rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign pat_ready  = w_ready;
    assign busy       = (state_q != S_IDLE);
    assign learn_done = learn_done_q;
    assign pat_count  = pat_count_q;
    assign rd_data    = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_hopfield_learner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hopfield_learner
//  Purpose  : Self-checking bench for hopfield_learner (WW=3 so that
//             saturation is reachable within MAX_PAT patterns). Reads are
//             queued with their expected value; a monitor pops and compares
//             when the registered read data becomes valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hopfield_learner;

    localparam int N       = 25;
    localparam int WW      = 3;
    localparam int MAX_PAT = 7;
    localparam int DEPTH   = N * N;
    localparam int WMAX    = (1 << (WW - 1)) - 1;
    localparam int WMIN    = -(1 << (WW - 1));
    localparam logic [N-1:0] PAT_D = 25'b0111010010100101001001111;
    localparam logic [N-1:0] PAT_J = 25'b1111000001000010000111110;
`ifdef ZERO_DIAG_EN
    localparam int DIAG_ONE = 0;
`else
    localparam int DIAG_ONE = 1;
`endif

    logic          clk;
    logic          rst;
    logic          clear;
    logic          pat_valid;
    logic [N-1:0]  pat_data;
    logic          pat_ready;
    logic          busy;
    logic          learn_done;
    logic [3:0]    pat_count;
    logic [9:0]    rd_addr;
    logic [WW-1:0] rd_data;

    int total = 0;
    int bad   = 0;
    int exp_cnt;
    int model [DEPTH];

    typedef struct {
        int addr;
        int exp;
    } rd_item_t;

    rd_item_t rdq [$];
    rd_item_t mon_item;
    logic     rd_req   = 1'b0;
    logic     rd_vld_q = 1'b0;

    hopfield_learner #(
        .N       (N),
        .WW      (WW),
        .MAX_PAT (MAX_PAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .pat_valid  (pat_valid),
        .pat_data   (pat_data),
        .pat_ready  (pat_ready),
        .busy       (busy),
        .learn_done (learn_done),
        .pat_count  (pat_count),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A read issued before an edge has its data on the following half cycle.
    always @(posedge clk) rd_vld_q <= rd_req;

    // Monitor: pop the expected value whenever read data is valid.
    always @(negedge clk) begin
        if (rd_vld_q) begin
            total++;
            if (rdq.size() == 0) begin
                bad++;
                $display("FAIL rd_scoreboard: got data %0d, expected no pending read",
                         $signed(rd_data));
            end else begin
                mon_item = rdq.pop_front();
                if (int'($signed(rd_data)) != mon_item.exp) begin
                    bad++;
                    $display("FAIL rd[%0d]: got %0d, expected %0d",
                             mon_item.addr, $signed(rd_data), mon_item.exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        if (v > WMAX) return WMAX;
        if (v < WMIN) return WMIN;
        return v;
    endfunction

    task automatic model_clear();
        for (int a = 0; a < DEPTH; a++) model[a] = 0;
    endtask

    task automatic model_learn(input logic [N-1:0] p);
        for (int k = 0; k < N; k++) begin
            for (int m = 0; m < N; m++) begin
                if (k == m) begin
`ifdef ZERO_DIAG_EN
                    model[k*N+m] = 0;
`else
                    model[k*N+m] = sat(model[k*N+m] + 1);
`endif
                end else begin
                    model[k*N+m] = sat(model[k*N+m] + ((p[k] == p[m]) ? 1 : -1));
                end
            end
        end
    endtask

    task automatic rd_push(input int a, input int e);
        rd_item_t it;
        tick();
        rd_addr = 10'(a);
        rd_req  = 1'b1;
        it.addr = a;
        it.exp  = e;
        rdq.push_back(it);
    endtask

    task automatic rd_end();
        tick();
        rd_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic sweep_model();
        for (int a = 0; a < DEPTH; a++) rd_push(a, model[a]);
        rd_push(700, 0);
        rd_push(1023, 0);
        rd_end();
    endtask

    // Called just after the edge that entered CLEAR (or reset release).
    task automatic wait_idle(input string name, input int exp);
        int c;
        int rdy_bad;
        int done_seen;
        c = 0;
        rdy_bad = 0;
        done_seen = 0;
        while (busy && c < 2000) begin
            tick();
            c++;
            if (busy && pat_ready) rdy_bad = 1;
            if (learn_done) done_seen = 1;
        end
        chk({name, " busy_cycles"}, c, exp);
        chk({name, " ready_while_busy"}, rdy_bad, 0);
        chk({name, " learn_done_seen"}, done_seen, 0);
        chk({name, " ready_after"}, int'(pat_ready), 1);
    endtask

    task automatic learn(input logic [N-1:0] p, input string name);
        int c;
        c = 0;
        while (!pat_ready && c < 100) begin
            tick();
            c++;
        end
        pat_valid = 1'b1;
        pat_data  = p;
        tick();
        pat_valid = 1'b0;
        pat_data  = ~p;
        chk({name, " busy_after_accept"}, int'(busy), 1);
        c = 0;
        while (!learn_done && c < 1000) begin
            tick();
            c++;
        end
        chk({name, " done_latency"}, c, 625);
        chk({name, " busy_at_done"}, int'(busy), 0);
        model_learn(p);
        if (exp_cnt < MAX_PAT) exp_cnt++;
        chk({name, " pat_count"}, int'(pat_count), exp_cnt);
        chk({name, " ready_at_done"}, int'(pat_ready), (exp_cnt < MAX_PAT) ? 1 : 0);
        tick();
        chk({name, " done_width"}, int'(learn_done), 0);
    endtask

    task automatic do_clear(input string name);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk({name, " busy"}, int'(busy), 1);
        chk({name, " pat_count"}, int'(pat_count), 0);
        model_clear();
        exp_cnt = 0;
        wait_idle(name, 625);
    endtask

    initial begin
        int busy_seen;
        int c;
        rst       = 1'b1;
        clear     = 1'b0;
        pat_valid = 1'b0;
        pat_data  = '0;
        rd_addr   = '0;
        exp_cnt   = 0;
        model_clear();

        // Reset values
        repeat (3) tick();
        chk("reset busy", int'(busy), 1);
        chk("reset pat_ready", int'(pat_ready), 0);
        chk("reset pat_count", int'(pat_count), 0);
        chk("reset learn_done", int'(learn_done), 0);
        chk("reset rd_data", int'(rd_data), 0);
        rst = 1'b0;
        wait_idle("post_reset_clear", 625);
        chk("idle pat_count", int'(pat_count), 0);
        sweep_model();

        // Single pattern D
        learn(PAT_D, "D1");
        rd_push(1, 1);
        rd_push(4, -1);
        rd_push(24*25 + 0, -1);
        rd_push(0, DIAG_ONE);
        rd_end();

        // D then J
        learn(PAT_J, "J1");
        rd_push(1, 0);
        rd_push(4, -2);
        rd_push(0, 2 * DIAG_ONE);
        rd_end();
        sweep_model();

        // Saturation: five times D from a clean store
        do_clear("clear_a");
        for (int i = 0; i < 5; i++) learn(PAT_D, "Dsat");
        rd_push(1, 3);
        rd_push(4, -4);
        rd_push(0, 3 * DIAG_ONE);
        rd_end();
        sweep_model();

        // Pattern limit
        learn(PAT_J, "J6");
        learn(PAT_D, "D7");
        chk("limit pat_ready", int'(pat_ready), 0);
        pat_valid = 1'b1;
        pat_data  = PAT_J;
        busy_seen = 0;
        repeat (10) begin
            tick();
            if (busy) busy_seen = 1;
        end
        pat_valid = 1'b0;
        chk("limit 8th rejected", busy_seen, 0);
        chk("limit pat_count", int'(pat_count), 7);
        do_clear("clear_b");
        sweep_model();

        // clear and pat_valid together: clear wins
        learn(PAT_D, "D_pre_clear");
        tick();
        clear     = 1'b1;
        pat_valid = 1'b1;
        pat_data  = PAT_J;
        #1;
        chk("clear_valid pat_ready", int'(pat_ready), 0);
        tick();
        clear     = 1'b0;
        pat_valid = 1'b0;
        chk("clear_valid busy", int'(busy), 1);
        chk("clear_valid pat_count", int'(pat_count), 0);
        model_clear();
        exp_cnt = 0;
        wait_idle("clear_valid", 625);
        chk("clear_valid pat_count_after", int'(pat_count), 0);

        // Reset 300 cycles into LEARN
        learn(PAT_D, "D_pre_reset");
        pat_valid = 1'b1;
        pat_data  = PAT_J;
        tick();
        pat_valid = 1'b0;
        repeat (300) tick();
        chk("mid_learn busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("async reset busy", int'(busy), 1);
        chk("async reset pat_count", int'(pat_count), 0);
        chk("async reset pat_ready", int'(pat_ready), 0);
        tick();
        tick();
        rst = 1'b0;
        model_clear();
        exp_cnt = 0;
        wait_idle("reset_mid_learn", 625);
        chk("reset_mid_learn pat_count", int'(pat_count), 0);
        sweep_model();

        c = 0;
        while (rdq.size() != 0 && c < 10) begin
            tick();
            c++;
        end
        chk("scoreboard drained", rdq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
